// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver (2-flop synchroniser, baud counter FSM) feeding a show-ahead FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit and a sticky parity_err output.
module uart_rx_fifo #(
    parameter int CLK_HZ        = 40000000,
    parameter int SCLK_HZ       = 115200,
    parameter int COUNTER_WIDTH = 9,
    parameter int FIFO_AW       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               uart_rxd,
    input  logic               rd_en,
    input  logic               clr_err,
    output logic [7:0]         rd_data,
    output logic               rd_valid,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overrun,
`ifdef UART_RX_PARITY_EN
    output logic               frame_err,
    output logic               parity_err
`else
    output logic               frame_err
`endif
);
    localparam int DIV = CLK_HZ / SCLK_HZ;
    localparam logic [COUNTER_WIDTH-1:0] HALF = COUNTER_WIDTH'(DIV / 2 - 1);
    localparam logic [COUNTER_WIDTH-1:0] LAST = COUNTER_WIDTH'(DIV - 1);
    localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW + 1)'(2 ** FIFO_AW);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HI} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
`endif

    state_t                   r_state;
    logic [1:0]               r_sync;
    logic [COUNTER_WIDTH-1:0] r_cnt;
    logic [2:0]               r_bit;
    logic [7:0]               r_shreg;
    logic [7:0]               r_mem [2**FIFO_AW];
    logic [FIFO_AW-1:0]       r_wp, r_rp;
    logic w_rxd, w_tick, w_push, w_fe, w_empty, w_full, w_pop, w_wr, w_ovr;

    assign w_rxd   = r_sync[1];
    assign w_tick  = r_cnt == LAST;
    assign w_push  = r_state == STOP && w_tick && w_rxd;
    assign w_fe    = r_state == STOP && w_tick && !w_rxd;
    assign w_empty = fifo_count == '0;
    assign w_full  = fifo_count == DEPTH;
    assign w_pop   = rd_en && !w_empty;
    // When full, a simultaneous pop frees the slot the push lands in
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_ovr   = w_push && w_full && !w_pop;
    assign rd_valid = !w_empty;
    assign rd_data  = w_empty ? 8'h00 : r_mem[r_rp];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync  <= 2'b11;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
        end else begin
            r_sync <= {r_sync[0], uart_rxd};
            case (r_state)
                IDLE: if (!w_rxd) begin
                    r_state <= START;
                    r_cnt   <= '0;
                end
                START: if (r_cnt == HALF) begin
                    r_state <= w_rxd ? IDLE : DATA;
                    r_cnt   <= '0;
                    r_bit   <= '0;
                end else r_cnt <= r_cnt + COUNTER_WIDTH'(1);
                DATA: if (w_tick) begin
                    r_shreg[r_bit] <= w_rxd;
                    r_bit <= r_bit + 3'd1;
                    r_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                    if (r_bit == 3'd7) r_state <= PARITY;
`else
                    if (r_bit == 3'd7) r_state <= STOP;
`endif
                end else r_cnt <= r_cnt + COUNTER_WIDTH'(1);
`ifdef UART_RX_PARITY_EN
                PARITY: if (w_tick) begin
                    r_state <= STOP;
                    r_cnt   <= '0;
                end else r_cnt <= r_cnt + COUNTER_WIDTH'(1);
`endif
                STOP: if (w_tick) begin
                    r_state <= w_rxd ? IDLE : WAIT_HI;
                    r_cnt   <= '0;
                end else r_cnt <= r_cnt + COUNTER_WIDTH'(1);
                WAIT_HI: if (w_rxd) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= r_shreg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp       <= '0;
            r_rp       <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            r_wp       <= r_wp + FIFO_AW'(w_wr);
            r_rp       <= r_rp + FIFO_AW'(w_pop);
            fifo_count <= fifo_count + (FIFO_AW + 1)'(w_wr) - (FIFO_AW + 1)'(w_pop);
            overrun    <= w_ovr || (overrun && !clr_err);
            frame_err  <= w_fe || (frame_err && !clr_err);
`ifdef UART_RX_PARITY_EN
            parity_err <= (r_state == PARITY && w_tick && (^r_shreg ^ w_rxd)) || (parity_err && !clr_err);
`endif
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: drives serial frames at DIV=16 and checks the FIFO and flags against a queue model.
module tb_uart_rx_fifo;
    logic clk = 0, reset = 1, uart_rxd = 1, rd_en = 0, clr_err = 0;
    logic [7:0] rd_data;
    logic rd_valid, overrun, frame_err;
    logic [4:0] fifo_count;
`ifdef UART_RX_PARITY_EN
    logic parity_err;
    bit exp_pe = 0;
`endif
    int checks = 0, failures = 0;
    logic [7:0] q[$];
    bit exp_ovr = 0, exp_fe = 0;

    uart_rx_fifo #(.CLK_HZ(16), .SCLK_HZ(1)) dut (
        .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .rd_en(rd_en), .clr_err(clr_err),
        .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count), .overrun(overrun),
`ifdef UART_RX_PARITY_EN
        .frame_err(frame_err), .parity_err(parity_err)
`else
        .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    // act: 0 none, 1 rd_en in the stop-sample cycle, 2 clr_err in that cycle
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par, input int act);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_RX_PARITY_EN
        bits.push_back(^d ^ bad_par);
`endif
        bits.push_back(stop);
        for (int b = 0; b < bits.size(); b++)
            for (int c = 0; c < 16; c++) begin
                uart_rxd = bits[b];
                if (b == bits.size() - 1 && c == 10) begin
                    if (act == 1) begin
                        checks++;
                        if (rd_data !== (q.size() > 0 ? q[0] : 8'h00)) begin
                            failures++;
                            $display("FAIL pop_head got=%h exp=%h", rd_data, q.size() > 0 ? q[0] : 8'h00);
                        end
                        rd_en = 1;
                    end
                    if (act == 2) clr_err = 1;
                end
                if (c == 11) begin
                    rd_en = 0;
                    clr_err = 0;
                end
                @(negedge clk);
            end
        uart_rxd = 1;
        if (act == 2) begin
            exp_ovr = 0;
            exp_fe = 0;
`ifdef UART_RX_PARITY_EN
            exp_pe = 0;
`endif
        end
`ifdef UART_RX_PARITY_EN
        if (bad_par) exp_pe = 1;
`endif
        if (act == 1 && q.size() > 0) q.delete(0);
        if (!stop) exp_fe = 1;
        else if (q.size() < 16) q.push_back(d);
        else exp_ovr = 1;
    endtask

    task automatic test_reset();
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rd_data); end
        checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_fe got=%b exp=0", frame_err); end
    endtask

    task automatic test_single();
        send_frame(8'hA5, 1, 0, 0);
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", rd_valid); end
        checks++; if (rd_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", rd_data); end
        checks++; if (fifo_count !== 5'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", fifo_count); end
        rd_en = 1; tick(1); rd_en = 0; q.delete(0);
        checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL single_pop_count got=%0d exp=0", fifo_count); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL single_pop_data got=%h exp=00", rd_data); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            send_frame(8'($urandom), 1, 0, int'($urandom_range(0, 1)));
            checks++; if (fifo_count !== 5'(q.size())) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", fifo_count, q.size()); end
            checks++; if (rd_data !== (q.size() > 0 ? q[0] : 8'h00)) begin failures++; $display("FAIL rand_head got=%h exp=%h", rd_data, q.size() > 0 ? q[0] : 8'h00); end
        end
        while (q.size() > 0) begin
            checks++; if (rd_data !== q[0]) begin failures++; $display("FAIL rand_drain got=%h exp=%h", rd_data, q[0]); end
            rd_en = 1; tick(1); rd_en = 0; q.delete(0);
        end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rand_empty got=%b exp=0", rd_valid); end
    endtask

    task automatic test_overrun();
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1, 0, 0);
        checks++; if (fifo_count !== 5'd16) begin failures++; $display("FAIL ovr_count got=%0d exp=16", fifo_count); end
        checks++; if (overrun !== exp_ovr) begin failures++; $display("FAIL ovr_flag got=%b exp=%b", overrun, exp_ovr); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (rd_data !== 8'(i)) begin failures++; $display("FAIL ovr_order got=%h exp=%h", rd_data, 8'(i)); end
            rd_en = 1; tick(1); rd_en = 0; q.delete(0);
        end
        rd_en = 1; tick(1); rd_en = 0;
        checks++; if (fifo_count !== 5'd0 || rd_data !== 8'h00) begin failures++; $display("FAIL empty_pop got=%0d/%h exp=0/00", fifo_count, rd_data); end
        clr_err = 1; tick(1); clr_err = 0; exp_ovr = 0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    endtask

    task automatic test_frame();
        send_frame(8'h3C, 0, 0, 0);
        checks++; if (frame_err !== exp_fe) begin failures++; $display("FAIL fe_flag got=%b exp=%b", frame_err, exp_fe); end
        checks++; if (fifo_count !== 5'(q.size())) begin failures++; $display("FAIL fe_count got=%0d exp=%0d", fifo_count, q.size()); end
        tick(20);
        send_frame(8'h3D, 1, 0, 0);
        checks++; if (rd_data !== 8'h3D || fifo_count !== 5'd1) begin failures++; $display("FAIL fe_next got=%h/%0d exp=3d/1", rd_data, fifo_count); end
        clr_err = 1; tick(1); clr_err = 0; exp_fe = 0;
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL fe_clear got=%b exp=0", frame_err); end
        rd_en = 1; tick(1); rd_en = 0; q.delete(0);
    endtask

    task automatic test_glitch();
        uart_rxd = 0; tick(4); uart_rxd = 1; tick(24);
        checks++; if (fifo_count !== 5'd0 || overrun !== 1'b0 || frame_err !== 1'b0) begin
            failures++; $display("FAIL glitch got=%0d/%b/%b exp=0/0/0", fifo_count, overrun, frame_err);
        end
        send_frame(8'h96, 1, 0, 0);
        checks++; if (rd_data !== 8'h96 || fifo_count !== 5'd1) begin failures++; $display("FAIL glitch_next got=%h/%0d exp=96/1", rd_data, fifo_count); end
        rd_en = 1; tick(1); rd_en = 0; q.delete(0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) send_frame(8'($urandom), 1, 0, 0);
        send_frame(8'($urandom), 1, 0, 1);
        checks++; if (fifo_count !== 5'd16) begin failures++; $display("FAIL fullpop_count got=%0d exp=16", fifo_count); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL fullpop_ovr got=%b exp=0", overrun); end
        send_frame(8'h11, 1, 0, 0);
        checks++; if (overrun !== exp_ovr) begin failures++; $display("FAIL full_drop got=%b exp=%b", overrun, exp_ovr); end
        send_frame(8'h22, 1, 0, 2);
        checks++; if (overrun !== exp_ovr) begin failures++; $display("FAIL clr_vs_set got=%b exp=%b", overrun, exp_ovr); end
        clr_err = 1; tick(1); clr_err = 0; exp_ovr = 0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL clr_only got=%b exp=0", overrun); end
        while (q.size() > 0) begin
            checks++; if (rd_data !== q[0]) begin failures++; $display("FAIL b2b_drain got=%h exp=%h", rd_data, q[0]); end
            rd_en = 1; tick(1); rd_en = 0; q.delete(0);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        send_frame(8'h01, 1, 1, 0);
        checks++; if (parity_err !== exp_pe) begin failures++; $display("FAIL par_flag got=%b exp=%b", parity_err, exp_pe); end
        checks++; if (rd_data !== 8'h01 || fifo_count !== 5'd1) begin failures++; $display("FAIL par_push got=%h/%0d exp=01/1", rd_data, fifo_count); end
        clr_err = 1; tick(1); clr_err = 0; exp_pe = 0;
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL par_clear got=%b exp=0", parity_err); end
        rd_en = 1; tick(1); rd_en = 0; q.delete(0);
    endtask
`endif

    task automatic test_reset_mid();
        send_frame(8'h77, 1, 0, 0);
        uart_rxd = 0; tick(40);
        reset = 1; #1;
        checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00 || fifo_count !== 5'd0 || overrun !== 1'b0 || frame_err !== 1'b0) begin
            failures++; $display("FAIL mid_reset got=%b/%h/%0d/%b/%b exp=0/00/0/0/0", rd_valid, rd_data, fifo_count, overrun, frame_err);
        end
`ifdef UART_RX_PARITY_EN
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL mid_reset_par got=%b exp=0", parity_err); end
        exp_pe = 0;
`endif
        q.delete(); exp_ovr = 0; exp_fe = 0;
        tick(3); uart_rxd = 1; tick(2); reset = 0; tick(20);
        send_frame(8'h5A, 1, 0, 0);
        checks++; if (rd_data !== 8'h5A || fifo_count !== 5'd1) begin failures++; $display("FAIL mid_after got=%h/%0d exp=5a/1", rd_data, fifo_count); end
    endtask

    initial begin
        tick(3);
        test_reset();
        reset = 0;
        tick(3);
        test_reset();
        test_single();
        test_random();
        test_overrun();
        test_frame();
        test_glitch();
        test_back_to_back();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
